issue_scoreboard: RTL and testbench

Parametrised N-wide in-order issue/hazard unit for the superscalar decode stage. It sits between fetch/decode and the ALU dispatch, and keeps a per-register scoreboard: a busy bit plus a ready-countdown. Each cycle it grants the longest hazard-free in-order prefix of the decoded slots and produces per-operand bypass selects. It replaces ad-hoc two-slot valid logic with generic width, register count and latency handling.

---
 rtl/issue_scoreboard_pkg.sv | 15 +
 rtl/issue_scoreboard_slot_check.sv | 68 ++++++
 rtl/issue_scoreboard.sv | 131 +++++++++++++
 tb/tb_issue_scoreboard.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared constants for the issue scoreboard (ISSUE_BYPASS_EN selects forwarding)
package issue_scoreboard_pkg;

   // Default width of the per-instruction result latency field
   localparam int LAT_W_DEF = 2;

   // Operand source select codes
   localparam logic [1:0] BYP_REGFILE = 2'b00;
   localparam logic [1:0] BYP_FWD     = 2'b01;

   // Result latencies driven by the main decoder onto slot_lat
   localparam int LAT_ALU  = 0;
   localparam int LAT_LOAD = 1;

endpackage

// File: rtl/issue_scoreboard_slot_check.sv
// rtl/issue_scoreboard_slot_check.sv - per-slot hazard and bypass check (ISSUE_BYPASS_EN enables forwarding)
module issue_slot_check
   import issue_scoreboard_pkg::*;
#(
   parameter int ISSUE_W = 2,
   parameter int NREG    = 32,
   parameter int RA_W    = 5,
   parameter int LAT_W   = LAT_W_DEF,
   parameter int SLOT    = 0
) (
   input  logic [NREG-1:0]         eb,
`ifdef ISSUE_BYPASS_EN
   input  logic [NREG*LAT_W-1:0]   cnt,
`endif
   input  logic [RA_W-1:0]         rs,
   input  logic [RA_W-1:0]         rt,
   input  logic                    use_rs,
   input  logic                    use_rt,
   input  logic [RA_W-1:0]         rd,
   input  logic                    we,
   input  logic [ISSUE_W*RA_W-1:0] all_rd,
   input  logic [ISSUE_W-1:0]      all_we,
   output logic                    ok,
   output logic [1:0]              byp_rs,
   output logic [1:0]              byp_rt
);

   logic fwd_rs;
   logic fwd_rt;
   logic haz_rs;
   logic haz_rt;
   logic waw_sb;
   logic raw_ig;
   logic waw_ig;
   logic [RA_W-1:0] rd_j;

   // Check this slot against the scoreboard and against every earlier slot in the group
   always_comb begin
      fwd_rs = 1'b0;
      fwd_rt = 1'b0;
`ifdef ISSUE_BYPASS_EN
      // A busy register whose countdown reached zero is on the forward network
      fwd_rs = eb[rs] && (cnt[rs*LAT_W +: LAT_W] == '0);
      fwd_rt = eb[rt] && (cnt[rt*LAT_W +: LAT_W] == '0);
`endif
      haz_rs = use_rs && eb[rs] && !fwd_rs;
      haz_rt = use_rt && eb[rt] && !fwd_rt;
      waw_sb = we && (rd != '0) && eb[rd];

      raw_ig = 1'b0;
      waw_ig = 1'b0;
      rd_j   = '0;
      for (int j = 0; j < ISSUE_W; j++) begin
         if (j < SLOT) begin
            rd_j = all_rd[j*RA_W +: RA_W];
            if (all_we[j] && (rd_j != '0)) begin
               if ((use_rs && (rs == rd_j)) || (use_rt && (rt == rd_j))) raw_ig = 1'b1;
               if (we && (rd == rd_j)) waw_ig = 1'b1;
            end
         end
      end

      ok     = !haz_rs && !haz_rt && !waw_sb && !raw_ig && !waw_ig;
      byp_rs = fwd_rs ? BYP_FWD : BYP_REGFILE;
      byp_rt = fwd_rt ? BYP_FWD : BYP_REGFILE;
   end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - N-wide in-order issue/hazard scoreboard (optional ISSUE_BYPASS_EN forwarding)
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int ISSUE_W = 2,
   parameter int NREG    = 32,
   parameter int RA_W    = 5,
   parameter int LAT_W   = LAT_W_DEF
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           hang,
   input  logic                           flush,
   input  logic [ISSUE_W-1:0]             slot_valid,
   input  logic [ISSUE_W*RA_W-1:0]        slot_rs,
   input  logic [ISSUE_W*RA_W-1:0]        slot_rt,
   input  logic [ISSUE_W-1:0]             slot_use_rs,
   input  logic [ISSUE_W-1:0]             slot_use_rt,
   input  logic [ISSUE_W*RA_W-1:0]        slot_rd,
   input  logic [ISSUE_W-1:0]             slot_we,
   input  logic [ISSUE_W*LAT_W-1:0]       slot_lat,
   input  logic [NREG-1:0]                wb_clr_mask,
   output logic [ISSUE_W-1:0]             issue_grant,
   output logic [$clog2(ISSUE_W+1)-1:0]   issue_count,
   output logic [ISSUE_W*2-1:0]           bypass_rs,
   output logic [ISSUE_W*2-1:0]           bypass_rt,
   output logic [NREG-1:0]                busy_mask
);

   localparam int CW = $clog2(ISSUE_W+1);

   logic [NREG-1:0]             busy_q;
   logic [NREG-1:0]             busy_d;
   logic [NREG-1:0][LAT_W-1:0]  cnt_q;
   logic [NREG-1:0][LAT_W-1:0]  cnt_d;
   logic [NREG-1:0]             eb;
   logic [ISSUE_W-1:0]          slot_ok;
   logic [ISSUE_W-1:0][1:0]     byp_rs_w;
   logic [ISSUE_W-1:0][1:0]     byp_rt_w;
   logic [ISSUE_W-1:0]          grant_c;
   logic                        chain;
   logic [CW-1:0]               count_c;
   logic [RA_W-1:0]             rd_i;

   // Writeback completing this cycle is readable thanks to the write-first regfile
   assign eb = busy_q & ~wb_clr_mask;

   genvar g;
   generate
      for (g = 0; g < ISSUE_W; g++) begin : g_slot
         issue_slot_check #(
            .ISSUE_W (ISSUE_W),
            .NREG    (NREG),
            .RA_W    (RA_W),
            .LAT_W   (LAT_W),
            .SLOT    (g)
         ) u_check (
            .eb      (eb),
`ifdef ISSUE_BYPASS_EN
            .cnt     (cnt_q),
`endif
            .rs      (slot_rs[g*RA_W +: RA_W]),
            .rt      (slot_rt[g*RA_W +: RA_W]),
            .use_rs  (slot_use_rs[g]),
            .use_rt  (slot_use_rt[g]),
            .rd      (slot_rd[g*RA_W +: RA_W]),
            .we      (slot_we[g]),
            .all_rd  (slot_rd),
            .all_we  (slot_we),
            .ok      (slot_ok[g]),
            .byp_rs  (byp_rs_w[g]),
            .byp_rt  (byp_rt_w[g])
         );
      end
   endgenerate

   // In-order prefix: a slot issues only if every older slot in the group issues
   always_comb begin
      chain     = !(RST || hang || flush);
      grant_c   = '0;
      count_c   = '0;
      bypass_rs = '0;
      bypass_rt = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         grant_c[i] = chain && slot_valid[i] && slot_ok[i];
         chain      = grant_c[i];
         count_c    = count_c + CW'(grant_c[i]);
         if (grant_c[i]) begin
            bypass_rs[i*2 +: 2] = byp_rs_w[i];
            bypass_rt[i*2 +: 2] = byp_rt_w[i];
         end
      end
   end

   assign issue_grant = grant_c;
   assign issue_count = count_c;
   assign busy_mask   = busy_q;

   // Scoreboard next state: clear, then count down, then set from this cycle's grants
   always_comb begin
      busy_d = busy_q & ~wb_clr_mask;
      cnt_d  = cnt_q;
      rd_i   = '0;
      if (!hang) begin
         for (int r = 0; r < NREG; r++) begin
            if (busy_d[r] && (cnt_q[r] != '0)) cnt_d[r] = cnt_q[r] - LAT_W'(1);
         end
         for (int i = 0; i < ISSUE_W; i++) begin
            rd_i = slot_rd[i*RA_W +: RA_W];
            if (grant_c[i] && slot_we[i] && (rd_i != '0)) begin
               busy_d[rd_i] = 1'b1;
               cnt_d[rd_i]  = slot_lat[i*LAT_W +: LAT_W];
            end
         end
      end
      if (RST) begin
         busy_d = '0;
         cnt_d  = '0;
      end
      // Register 0 is hardwired zero and never tracked
      busy_d[0] = 1'b0;
      cnt_d[0]  = '0;
   end

   // Scoreboard registers
   always_ff @(posedge CLK) begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - self-checking bench for issue_scoreboard with a behavioural scoreboard model
module tb_issue_scoreboard;
   import issue_scoreboard_pkg::*;

   localparam int W  = 2;
   localparam int NR = 32;
   localparam int RA = 5;
   localparam int LW = 2;
   localparam int CW = $clog2(W+1);
`ifdef ISSUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RST, hang, flush;
   logic [W-1:0]    slot_valid, slot_use_rs, slot_use_rt, slot_we;
   logic [W*RA-1:0] slot_rs, slot_rt, slot_rd;
   logic [W*LW-1:0] slot_lat;
   logic [NR-1:0]   wb_clr_mask;
   logic [W-1:0]    issue_grant;
   logic [CW-1:0]   issue_count;
   logic [W*2-1:0]  bypass_rs, bypass_rt;
   logic [NR-1:0]   busy_mask;

   issue_scoreboard #(.ISSUE_W(W), .NREG(NR), .RA_W(RA), .LAT_W(LW)) dut (
      .CLK(CLK), .RST(RST), .hang(hang), .flush(flush),
      .slot_valid(slot_valid), .slot_rs(slot_rs), .slot_rt(slot_rt),
      .slot_use_rs(slot_use_rs), .slot_use_rt(slot_use_rt),
      .slot_rd(slot_rd), .slot_we(slot_we), .slot_lat(slot_lat),
      .wb_clr_mask(wb_clr_mask), .issue_grant(issue_grant),
      .issue_count(issue_count), .bypass_rs(bypass_rs), .bypass_rt(bypass_rt),
      .busy_mask(busy_mask)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int m_busy[NR];
   int m_cnt[NR];
   logic [W-1:0]   e_grant;
   logic [W*2-1:0] e_brs, e_brt;

   function automatic bit eff_busy(int r);
      return (m_busy[r] != 0) && !wb_clr_mask[r];
   endfunction

   function automatic bit fwd_ok(int r);
      return BYP && (m_cnt[r] == 0);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_slot(input int i, input bit v, input int a, input int b, input bit ua,
                           input bit ub, input int d, input bit w, input int l);
      slot_valid[i]           = v;
      slot_rs[i*RA +: RA]     = RA'(a);
      slot_rt[i*RA +: RA]     = RA'(b);
      slot_use_rs[i]          = ua;
      slot_use_rt[i]          = ub;
      slot_rd[i*RA +: RA]     = RA'(d);
      slot_we[i]              = w;
      slot_lat[i*LW +: LW]    = LW'(l);
   endtask

   task automatic idle();
      slot_valid = '0; slot_use_rs = '0; slot_use_rt = '0; slot_we = '0;
      slot_rs = '0; slot_rt = '0; slot_rd = '0; slot_lat = '0;
      wb_clr_mask = '0; hang = 1'b0; flush = 1'b0;
   endtask

   // Expected grants: longest prefix of slots whose operands and destination are hazard free
   task automatic compute_expected();
      bit go;
      bit ok;
      int a, b, d, dj;
      e_grant = '0; e_brs = '0; e_brt = '0;
      go = !(RST || hang || flush);
      for (int i = 0; i < W; i++) begin
         a = int'(slot_rs[i*RA +: RA]);
         b = int'(slot_rt[i*RA +: RA]);
         d = int'(slot_rd[i*RA +: RA]);
         ok = go && slot_valid[i];
         if (slot_use_rs[i] && eff_busy(a) && !fwd_ok(a)) ok = 0;
         if (slot_use_rt[i] && eff_busy(b) && !fwd_ok(b)) ok = 0;
         if (slot_we[i] && d != 0 && eff_busy(d)) ok = 0;
         for (int j = 0; j < i; j++) begin
            dj = int'(slot_rd[j*RA +: RA]);
            if (slot_we[j] && dj != 0) begin
               if ((slot_use_rs[i] && a == dj) || (slot_use_rt[i] && b == dj)) ok = 0;
               if (slot_we[i] && d == dj) ok = 0;
            end
         end
         if (ok) begin
            e_grant[i] = 1'b1;
            e_brs[i*2 +: 2] = (eff_busy(a) && fwd_ok(a)) ? BYP_FWD : BYP_REGFILE;
            e_brt[i*2 +: 2] = (eff_busy(b) && fwd_ok(b)) ? BYP_FWD : BYP_REGFILE;
         end
         go = ok;
      end
   endtask

   task automatic model_update();
      int d;
      if (RST) begin
         for (int r = 0; r < NR; r++) begin m_busy[r] = 0; m_cnt[r] = 0; end
      end else begin
         for (int r = 0; r < NR; r++) if (wb_clr_mask[r]) m_busy[r] = 0;
         if (!hang) begin
            for (int r = 0; r < NR; r++) if (m_busy[r] != 0 && m_cnt[r] > 0) m_cnt[r]--;
            for (int i = 0; i < W; i++) begin
               d = int'(slot_rd[i*RA +: RA]);
               if (e_grant[i] && slot_we[i] && d != 0) begin
                  m_busy[d] = 1;
                  m_cnt[d]  = int'(slot_lat[i*LW +: LW]);
               end
            end
         end
      end
   endtask

   // One cycle: check combinational outputs and state against the model, then clock both
   task automatic step(input string tag);
      logic [NR-1:0] mb;
      #2;
      compute_expected();
      for (int r = 0; r < NR; r++) mb[r] = (m_busy[r] != 0);
      chk({tag, ".grant"}, 64'(issue_grant), 64'(e_grant));
      chk({tag, ".count"}, 64'(issue_count), 64'($countones(e_grant)));
      chk({tag, ".byp_rs"}, 64'(bypass_rs), 64'(e_brs));
      chk({tag, ".byp_rt"}, 64'(bypass_rt), 64'(e_brt));
      chk({tag, ".busy"}, 64'(busy_mask), 64'(mb));
      @(posedge CLK);
      model_update();
      #1;
   endtask

   initial begin
      for (int r = 0; r < NR; r++) begin m_busy[r] = 0; m_cnt[r] = 0; end
      idle();
      RST = 1'b1;
      @(posedge CLK);
      #1;
      // Reset holds grants low even with valid work
      set_slot(0, 1, 1, 2, 1, 1, 3, 1, LAT_ALU);
      set_slot(1, 1, 1, 2, 1, 1, 4, 1, LAT_ALU);
      step("reset");
      chk("reset.grant0", 64'(issue_grant), 64'(0));
      RST = 1'b0;

      // Two independent adds issue together
      step("dual_add");
      idle();
      #2;
      chk("dual_add.busy34", 64'(busy_mask[4:3]), 64'(2'b11));
      step("after_dual");

      // Intra-group RAW on r5
      set_slot(0, 1, 1, 2, 1, 1, 5, 1, LAT_ALU);
      set_slot(1, 1, 5, 1, 1, 1, 6, 1, LAT_ALU);
      #2;
      chk("raw.grant", 64'(issue_grant), 64'(2'b01));
      step("raw");
      idle();
      set_slot(0, 1, 5, 1, 1, 1, 6, 1, LAT_ALU);
      #2;
      chk("raw_next.grant", 64'(issue_grant), 64'(BYP ? 2'b01 : 2'b00));
      chk("raw_next.byp_rs", 64'(bypass_rs), 64'(BYP ? 4'b0001 : 4'b0000));
      step("raw_next");
      idle();

      // Load then dependent add
      set_slot(0, 1, 1, 0, 1, 0, 7, 1, LAT_LOAD);
      step("lw");
      idle();
      set_slot(0, 1, 7, 0, 1, 1, 8, 1, LAT_ALU);
      step("lw_use0");
      #2;
      chk("lw_use1.grant", 64'(issue_grant), 64'(BYP ? 2'b01 : 2'b00));
      step("lw_use1");
      if (!BYP) begin
         step("lw_use2");
         wb_clr_mask[7] = 1'b1;
         step("lw_use_clr");
      end
      idle();

      // Writeback of r9 completes in the same cycle it is read
      set_slot(0, 1, 1, 2, 1, 1, 9, 1, LAT_LOAD);
      step("wr9");
      idle();
      set_slot(0, 1, 9, 9, 1, 1, 13, 1, LAT_ALU);
      wb_clr_mask[9] = 1'b1;
      #2;
      chk("clr9.grant", 64'(issue_grant), 64'(2'b01));
      chk("clr9.byp", 64'({bypass_rs, bypass_rt}), 64'(0));
      step("clr9");
      idle();

      // Flush kills issue and keeps state
      set_slot(0, 1, 1, 2, 1, 1, 10, 1, LAT_ALU);
      set_slot(1, 1, 1, 2, 1, 1, 11, 1, LAT_ALU);
      flush = 1'b1;
      step("flush");
      flush = 1'b0;
      idle();

      // Hang freezes the countdown of an outstanding load
      set_slot(0, 1, 1, 0, 1, 0, 12, 1, LAT_LOAD);
      step("lw12");
      idle();
      set_slot(0, 1, 12, 0, 1, 0, 14, 1, LAT_ALU);
      hang = 1'b1;
      step("hang0");
      step("hang1");
      hang = 1'b0;
      step("hang_rel0");
      step("hang_rel1");
      idle();

      // Two r0 writers in one group
      set_slot(0, 1, 1, 2, 1, 1, 0, 1, LAT_ALU);
      set_slot(1, 1, 1, 2, 1, 1, 0, 1, LAT_ALU);
      #2;
      chk("r0.grant", 64'(issue_grant), 64'(2'b11));
      step("r0");
      idle();
      #2;
      chk("r0.busy0", 64'(busy_mask[0]), 64'(0));
      step("r0_after");

      // Randomised traffic on a small register window to provoke hazards
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < W; i++)
            set_slot(i, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom_range(0, 3));
         wb_clr_mask = NR'($urandom & $urandom);
         hang  = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 7) == 0);
         RST   = ($urandom_range(0, 39) == 0);
         step("rand");
      end
      RST = 1'b0;
      idle();
      step("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
